// File: rtl/gemm_pkg.sv
// Shared types and width defaults for the GEMM array sequencer slice.
package gemm_pkg;

  localparam int unsigned NumInputsDef    = 4;
  localparam int unsigned InDataWidthDef  = 8;
  localparam int unsigned OutDataWidthDef = 32;
  localparam int unsigned KDimDef         = 4;
  localparam int unsigned AddrWidthDef    = 8;

  typedef enum logic [1:0] {
    ACC_LOCAL = 2'b00,
    ACC_SOUTH = 2'b01,
    ACC_EAST  = 2'b10
  } acc_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SETTLE,
    ST_FLUSH,
    ST_DONE
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gemm_array_sequencer_if.sv
// Sequencer bus: start/status, operand SRAM reads, array edge, C SRAM writes.
interface gemm_array_sequencer_if
  import gemm_pkg::*;
#(
  parameter int unsigned NumInputs    = NumInputsDef,
  parameter int unsigned InDataWidth  = InDataWidthDef,
  parameter int unsigned OutDataWidth = OutDataWidthDef,
  parameter int unsigned AddrWidth    = AddrWidthDef
);
  logic                              start_i;
  logic                              busy_o;
  logic                              done_o;
  logic [AddrWidth-1:0]              sram_a_raddr_o;
  logic [AddrWidth-1:0]              sram_b_raddr_o;
  logic                              sram_ab_re_o;
  logic [NumInputs*InDataWidth-1:0]  sram_a_rdata_i;
  logic [NumInputs*InDataWidth-1:0]  sram_b_rdata_i;
  logic                              arr_valid_o;
  logic [NumInputs*InDataWidth-1:0]  arr_a_o;
  logic [NumInputs*InDataWidth-1:0]  arr_b_o;
  logic [1:0]                        arr_acc_mux_sel_o;
  logic [NumInputs*OutDataWidth-1:0] arr_c_i;
  logic                              sram_c_we_o;
  logic [AddrWidth-1:0]              sram_c_waddr_o;
  logic [NumInputs*OutDataWidth-1:0] sram_c_wdata_o;

  modport master (
    input  start_i, sram_a_rdata_i, sram_b_rdata_i, arr_c_i,
    output busy_o, done_o, sram_a_raddr_o, sram_b_raddr_o, sram_ab_re_o,
           arr_valid_o, arr_a_o, arr_b_o, arr_acc_mux_sel_o,
           sram_c_we_o, sram_c_waddr_o, sram_c_wdata_o
  );

  modport slave (
    output start_i, sram_a_rdata_i, sram_b_rdata_i, arr_c_i,
    input  busy_o, done_o, sram_a_raddr_o, sram_b_raddr_o, sram_ab_re_o,
           arr_valid_o, arr_a_o, arr_b_o, arr_acc_mux_sel_o,
           sram_c_we_o, sram_c_waddr_o, sram_c_wdata_o
  );
endinterface

// File: rtl/gemm_skew_buffer.sv
// Diagonal skew: a load-zero input stage shared by all lanes, then lane i adds i
// more register stages so lane i lags lane 0 by i cycles.
module gemm_skew_buffer #(
  parameter int unsigned NumInputs = 4,
  parameter int unsigned DataWidth = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           load_i,
  input  logic [NumInputs*DataWidth-1:0] data_i,
  output logic [NumInputs*DataWidth-1:0] data_o
);

  for (genvar i = 0; i < NumInputs; i++) begin : g_lane
    logic [DataWidth-1:0] pipe_q [i+1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int d = 0; d <= i; d++) pipe_q[d] <= '0;
      end else begin
        pipe_q[0] <= load_i ? data_i[i*DataWidth +: DataWidth] : '0;
        for (int d = 1; d <= i; d++) pipe_q[d] <= pipe_q[d-1];
      end
    end

    assign data_o[i*DataWidth +: DataWidth] = pipe_q[i];
  end

endmodule

// File: rtl/gemm_array_sequencer.sv
// Runs one output tile on the 4x4 output-stationary array: operand fetch and
// skew, valid/acc-select sequencing, eastward drain into the C SRAM.
module gemm_array_sequencer
  import gemm_pkg::*;
#(
  parameter int unsigned NumInputs    = NumInputsDef,
  parameter int unsigned InDataWidth  = InDataWidthDef,
  parameter int unsigned OutDataWidth = OutDataWidthDef,
  parameter int unsigned KDim         = KDimDef,
  parameter int unsigned DrainCycles  = NumInputs - 1,
  parameter int unsigned AddrWidth    = AddrWidthDef
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  gemm_array_sequencer_if.master bus
);

  // SETTLE spans from the cycle after the last read to the last valid cycle.
  localparam int unsigned SettleCycles = NumInputs + DrainCycles + 1;
  localparam int unsigned CntMax       = max_u(max_u(KDim, SettleCycles), NumInputs);
  localparam int unsigned CntW         = $clog2(CntMax) + 1;

  seq_state_e                        state_q, state_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic                              re_q, re_d;
  logic                              rd_valid_q;
  logic [AddrWidth-1:0]              raddr_q, raddr_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              valid_q, valid_d;
  acc_sel_e                          acc_sel_q, acc_sel_d;
  logic                              we_q, we_d;
  logic [AddrWidth-1:0]              waddr_q, waddr_d;
  logic [NumInputs*OutDataWidth-1:0] wdata_q, wdata_d;

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        if (cnt_q == CntW'(KDim - 1)) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CntW'(SettleCycles - 1)) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CntW'(NumInputs - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    re_d      = (state_d == ST_READ);
    raddr_d   = re_d ? AddrWidth'(cnt_d) : '0;
    busy_d    = (state_d == ST_READ) || (state_d == ST_SETTLE) || (state_d == ST_FLUSH);
    done_d    = (state_d == ST_DONE);
    // Valid rises one cycle after the first read data returns and holds until FLUSH.
    valid_d   = (rd_valid_q || valid_q) && ((state_d == ST_READ) || (state_d == ST_SETTLE));
    acc_sel_d = (state_d == ST_FLUSH) ? ACC_EAST : ACC_LOCAL;
    we_d      = (state_q == ST_FLUSH);
    waddr_d   = we_d ? (AddrWidth'(NumInputs - 1) - AddrWidth'(cnt_q)) : '0;
    wdata_d   = we_d ? bus.arr_c_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      re_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      raddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      acc_sel_q  <= ACC_LOCAL;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      re_q       <= re_d;
      rd_valid_q <= re_q;
      raddr_q    <= raddr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      acc_sel_q  <= acc_sel_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  gemm_skew_buffer #(.NumInputs(NumInputs), .DataWidth(InDataWidth)) u_skew_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (rd_valid_q),
    .data_i (bus.sram_a_rdata_i),
    .data_o (bus.arr_a_o)
  );

  gemm_skew_buffer #(.NumInputs(NumInputs), .DataWidth(InDataWidth)) u_skew_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (rd_valid_q),
    .data_i (bus.sram_b_rdata_i),
    .data_o (bus.arr_b_o)
  );

  assign bus.busy_o            = busy_q;
  assign bus.done_o            = done_q;
  assign bus.sram_a_raddr_o    = raddr_q;
  assign bus.sram_b_raddr_o    = raddr_q;
  assign bus.sram_ab_re_o      = re_q;
  assign bus.arr_valid_o       = valid_q;
  assign bus.arr_acc_mux_sel_o = acc_sel_q;
  assign bus.sram_c_we_o       = we_q;
  assign bus.sram_c_waddr_o    = waddr_q;
  assign bus.sram_c_wdata_o    = wdata_q;

endmodule

// File: tb/tb_gemm_array_sequencer.sv
// Directed bench: operand SRAM and 4x4 output-stationary array models around the sequencer.
module tb_gemm_array_sequencer;

  logic clk_i;
  logic rst_ni;

  int vectors;
  int miscompares;

  gemm_array_sequencer_if #(.NumInputs(4), .InDataWidth(8), .OutDataWidth(32), .AddrWidth(8)) bus ();

  gemm_array_sequencer #(
    .NumInputs(4), .InDataWidth(8), .OutDataWidth(32), .KDim(4), .DrainCycles(3), .AddrWidth(8)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Operand matrices and their SRAM images.
  int          amat [4][4];
  int          bmat [4][4];
  logic [31:0] amem [4];
  logic [31:0] bmem [4];

  always @(posedge clk_i) begin
    if (bus.sram_ab_re_o) begin
      bus.sram_a_rdata_i <= amem[bus.sram_a_raddr_o[1:0]];
      bus.sram_b_rdata_i <= bmem[bus.sram_b_raddr_o[1:0]];
    end
  end

  // Behavioural output-stationary array: MAC on valid, shift east on ACC_EAST.
  logic signed [31:0] acc [4][4];
  logic signed [7:0]  ar  [4][4];
  logic signed [7:0]  br  [4][4];

  always @(posedge clk_i or negedge rst_ni) begin : array_model
    logic signed [7:0] ain, bin;
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          acc[i][j] <= '0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end
    end else if (bus.arr_acc_mux_sel_o == 2'b10) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          acc[i][j] <= (j == 0) ? 32'sd0 : acc[i][j-1];
    end else if (bus.arr_valid_o) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ain = (j == 0) ? $signed(bus.arr_a_o[i*8 +: 8]) : ar[i][j-1];
          bin = (i == 0) ? $signed(bus.arr_b_o[j*8 +: 8]) : br[i-1][j];
          acc[i][j] <= acc[i][j] + 32'(ain) * 32'(bin);
          ar[i][j]  <= ain;
          br[i][j]  <= bin;
        end
    end
  end

  always_comb begin
    bus.arr_c_i = '0;
    for (int i = 0; i < 4; i++) bus.arr_c_i[i*32 +: 32] = acc[i][3];
  end

  // Per-tile observations, all written by the stimulus process.
  int           valid_cnt, done_cnt, re_cnt, wr_n, sel_err, east_cnt, done_n, t_idx;
  logic [7:0]   re_addr [8];
  logic [7:0]   wr_addr [8];
  logic [127:0] wr_data [8];
  logic [31:0]  a_hist  [12];
  logic [31:0]  b_hist  [12];
  logic [31:0]  skew_exp [11];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_mats();
    for (int k = 0; k < 4; k++) begin
      amem[k] = '0;
      bmem[k] = '0;
      for (int l = 0; l < 4; l++) begin
        amem[k][l*8 +: 8] = 8'(amat[l][k]);
        bmem[k][l*8 +: 8] = 8'(bmat[k][l]);
      end
    end
  endtask

  // Drives one tile and records what the DUT does, cycle by cycle at negedge.
  task automatic run_tile(input bit issue_start, input bit poke_read, input bit poke_done,
                          input bit chain, input int abort_n);
    if (issue_start) begin
      @(negedge clk_i);
      start_i_drive(1'b1);
    end
    valid_cnt = 0; done_cnt = 0; re_cnt = 0; wr_n = 0; sel_err = 0; east_cnt = 0;
    done_n = 0; t_idx = -1;
    for (int h = 0; h < 12; h++) begin
      a_hist[h] = '1;
      b_hist[h] = '1;
    end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      start_i_drive(poke_read && (n == 2));
      if (bus.arr_valid_o) begin
        valid_cnt++;
        if (t_idx < 0) t_idx = 0;
        if (bus.arr_acc_mux_sel_o != 2'b00) sel_err++;
      end
      if (t_idx >= 0) begin
        if (t_idx < 12) begin
          a_hist[t_idx] = bus.arr_a_o;
          b_hist[t_idx] = bus.arr_b_o;
        end
        t_idx++;
      end
      if (bus.arr_acc_mux_sel_o == 2'b10) east_cnt++;
      if (bus.sram_ab_re_o) begin
        if (re_cnt < 8) re_addr[re_cnt] = bus.sram_a_raddr_o;
        re_cnt++;
      end
      if (bus.sram_c_we_o) begin
        if (wr_n < 8) begin
          wr_addr[wr_n] = bus.sram_c_waddr_o;
          wr_data[wr_n] = bus.sram_c_wdata_o;
        end
        wr_n++;
      end
      if (abort_n == n) begin
        chk("we_before_abort", 64'(bus.sram_c_we_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("we_async_clear", 64'(bus.sram_c_we_o), 64'd0);
        chk("busy_async_clear", 64'(bus.busy_o), 64'd0);
        break;
      end
      if (bus.done_o) begin
        done_cnt++;
        done_n = n;
        if (poke_done) start_i_drive(1'b1);
      end
      if (chain && (done_n > 0) && (n == done_n + 1)) begin
        start_i_drive(1'b1);
        break;
      end
    end
  endtask

  task automatic start_i_drive(input logic v);
    bus.start_i = v;
  endtask

  // Compares the recorded tile against a golden matrix product.
  task automatic check_tile(input string name);
    int gold [4][4];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        gold[i][j] = 0;
        for (int k = 0; k < 4; k++) gold[i][j] += amat[i][k] * bmat[k][j];
      end
    chk({name, ".done_cnt"},  64'(done_cnt),  64'd1);
    chk({name, ".valid_cnt"}, 64'(valid_cnt), 64'd10);
    chk({name, ".re_cnt"},    64'(re_cnt),    64'd4);
    chk({name, ".wr_n"},      64'(wr_n),      64'd4);
    chk({name, ".sel_err"},   64'(sel_err),   64'd0);
    chk({name, ".east_cnt"},  64'(east_cnt),  64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s.raddr%0d", name, k), 64'(re_addr[k]), 64'(k));
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("%s.waddr%0d", name, w), 64'(wr_addr[w]), 64'(3 - w));
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s.C[%0d][%0d]", name, i, 3 - w),
            $signed(wr_data[w][i*32 +: 32]), 64'(gold[i][3-w]));
    end
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        amat[i][k] = -i * k;
        bmat[k][i] = i - 1;
      end
    load_mats();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    skew_exp[0] = 32'h0000_0001; skew_exp[1] = 32'h0000_0101; skew_exp[2]  = 32'h0001_0101;
    skew_exp[3] = 32'h0101_0101; skew_exp[4] = 32'h0101_0100; skew_exp[5]  = 32'h0101_0000;
    skew_exp[6] = 32'h0100_0000; skew_exp[7] = 32'h0000_0000; skew_exp[8]  = 32'h0000_0000;
    skew_exp[9] = 32'h0000_0000; skew_exp[10] = 32'h0000_0000;

    // Reset held with start asserted: everything stays quiet.
    rst_ni = 1'b0;
    bus.start_i = 1'b1;
    bus.sram_a_rdata_i = '0;
    bus.sram_b_rdata_i = '0;
    set_nominal();
    repeat (3) @(negedge clk_i);
    chk("rst.busy",  64'(bus.busy_o),            64'd0);
    chk("rst.done",  64'(bus.done_o),            64'd0);
    chk("rst.re",    64'(bus.sram_ab_re_o),      64'd0);
    chk("rst.raddr", 64'(bus.sram_a_raddr_o),    64'd0);
    chk("rst.valid", 64'(bus.arr_valid_o),       64'd0);
    chk("rst.sel",   64'(bus.arr_acc_mux_sel_o), 64'd0);
    chk("rst.arr_a", 64'(bus.arr_a_o),           64'd0);
    chk("rst.we",    64'(bus.sram_c_we_o),       64'd0);
    chk("rst.wdata", 64'(bus.sram_c_wdata_o[63:0]), 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Nominal tile with hand-computed spot values.
    run_tile(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_tile("nominal");
    chk("nominal.hand_C20", $signed(wr_data[3][2*32 +: 32]), 64'sd12);
    chk("nominal.hand_C33", $signed(wr_data[0][3*32 +: 32]), -64'sd36);
    chk("nominal.hand_C12", $signed(wr_data[1][1*32 +: 32]), -64'sd6);
    chk("nominal.hand_C01", $signed(wr_data[2][0*32 +: 32]), 64'sd0);

    // All-ones operands expose the diagonal skew pattern on both edges.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        amat[i][k] = 1;
        bmat[k][i] = 1;
      end
    load_mats();
    run_tile(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_tile("ones");
    for (int t = 0; t < 11; t++) begin
      chk($sformatf("skew.a_t%0d", t), 64'(a_hist[t]), 64'(skew_exp[t]));
      chk($sformatf("skew.b_t%0d", t), 64'(b_hist[t]), 64'(skew_exp[t]));
    end

    // Start pulses during READ and during DONE must be ignored.
    set_nominal();
    run_tile(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check_tile("poke");
    chk("poke.idle_busy", 64'(bus.busy_o), 64'd0);

    // Reset in the second FLUSH cycle, then a clean rerun.
    run_tile(1'b1, 1'b0, 1'b0, 1'b0, 14);
    @(negedge clk_i);
    chk("abort.we_held", 64'(bus.sram_c_we_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_tile(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_tile("after_abort");

    // Back-to-back tiles with different operands.
    run_tile(1'b1, 1'b0, 1'b0, 1'b1, 0);
    check_tile("b2b_first");
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        amat[i][k] = i + k + 1;
        bmat[k][i] = ((k % 2) == 1) ? -(i + 1) : 2 * (i + 1);
      end
    load_mats();
    run_tile(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_tile("b2b_second");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
